// File: rtl/sar_ctrl.sv
// Successive-approximation ADC controller: binary search over an Nbits DAC code
// against a synchronized comparator. Optional result transmission under SAR_TX_EN.
module sar_ctrl #(
  parameter int Nbits        = 8,
  parameter int SettleCycles = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             cmp_i,
  output logic [Nbits-1:0] dac_o,
  output logic [Nbits-1:0] dout_o,
  output logic             busy_o,
  output logic             eoc_o,
  output logic             tx_stt_o,
  output logic [7:0]       tx_din_o,
  input  logic             tx_eot_i
);

  localparam int IW = (Nbits > 2) ? $clog2(Nbits) : 1;
  localparam int CW = $clog2(SettleCycles + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, DECIDE, DONE, SEND, WAIT_TX} state_t;

  state_t           state;
  logic [1:0]       cmp_q;
  logic             cmp_s;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [Nbits-1:0] decided;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cmp_q <= '0;
    else        cmp_q <= {cmp_q[0], cmp_i};
  end
  assign cmp_s = cmp_q[1];

  // Trial bit survives only if Vin >= Vdac.
  always_comb begin
    decided = dac_o;
    if (!cmp_s) decided[idx] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      dac_o  <= '0;
      dout_o <= '0;
      busy_o <= 1'b0;
      eoc_o  <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
    end else begin
      eoc_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state  <= SETTLE;
          busy_o <= 1'b1;
          dac_o  <= Nbits'(1) << (Nbits - 1);
          idx    <= IW'(Nbits - 1);
          cnt    <= '0;
        end
        SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SettleCycles - 1)) state <= DECIDE;
        end
        DECIDE: begin
          if (idx != '0) begin
            dac_o <= decided | (Nbits'(1) << (idx - 1'b1));
            idx   <= idx - 1'b1;
            cnt   <= '0;
            state <= SETTLE;
          end else begin
            dac_o  <= decided;
            dout_o <= decided;
            eoc_o  <= 1'b1;
            state  <= DONE;
          end
        end
`ifdef SAR_TX_EN
        DONE:    state <= SEND;
        SEND:    state <= WAIT_TX;
        WAIT_TX: if (tx_eot_i) begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
`else
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SAR_TX_EN
  // Strobe and byte are launched together on the DONE->SEND edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tx_stt_o <= 1'b0;
      tx_din_o <= '0;
    end else begin
      tx_stt_o <= (state == DONE);
      if (state == DONE) tx_din_o <= 8'(dout_o);
    end
  end
`else
  logic unused_tx_eot;
  assign unused_tx_eot = tx_eot_i;
  assign tx_stt_o      = 1'b0;
  assign tx_din_o      = '0;
`endif

endmodule

// File: tb/tb_sar_ctrl.sv
// Bench for sar_ctrl: ideal comparator, time-based reference model checked every
// cycle, plus directed literal checks of trial codes, latency, reset and ignored starts.
module tb_sar_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       start_i = 1'b0;
  logic       cmp_i;
  logic       tx_eot_i = 1'b0;
  logic [7:0] dac_o, dout_o, tx_din_o;
  logic       busy_o, eoc_o, tx_stt_o;
  logic [7:0] vin = 8'h00;

  int tests = 0;
  int fails = 0;

`ifdef SAR_TX_EN
  localparam bit TX = 1'b1;
`else
  localparam bit TX = 1'b0;
`endif

  always #5 clk = ~clk;
  assign cmp_i = (vin >= dac_o);

  sar_ctrl #(.Nbits(8), .SettleCycles(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .cmp_i(cmp_i),
    .dac_o(dac_o), .dout_o(dout_o), .busy_o(busy_o), .eoc_o(eoc_o),
    .tx_stt_o(tx_stt_o), .tx_din_o(tx_din_o), .tx_eot_i(tx_eot_i)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Trial code of binary-search step b: top b bits of the answer, then a probe bit.
  function automatic logic [7:0] trial(input logic [7:0] v, input int b);
    logic [7:0] m;
    m = 8'hFF;
    m = m << (8 - b);
    return (v & m) | (8'h80 >> b);
  endfunction

  // Model: j counts edges since the accepted start; conversion ends at j=40.
  bit         m_act   = 1'b0;
  int         m_j     = 0;
  logic [7:0] m_vin   = 8'h00;
  logic [7:0] m_dac   = 8'h00;
  logic [7:0] m_dout  = 8'h00;
  logic [7:0] m_txdin = 8'h00;

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_act <= 1'b0; m_j <= 0; m_dac <= 8'h00; m_dout <= 8'h00; m_txdin <= 8'h00;
    end else if (!m_act) begin
      if (start_i) begin m_act <= 1'b1; m_j <= 0; m_vin <= vin; end
    end else if (m_j == 39) begin
      m_j <= 40; m_dac <= m_vin; m_dout <= m_vin;
    end else if (m_j == 40) begin
      if (TX) begin m_j <= 41; m_txdin <= m_vin; end
      else m_act <= 1'b0;
    end else if (m_j == 41) begin
      m_j <= 42;
    end else if (m_j == 42) begin
      if (tx_eot_i) m_act <= 1'b0;
    end else begin
      m_j <= m_j + 1;
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_dac;
    exp_dac = (m_act && m_j < 40) ? trial(m_vin, m_j / 5) : m_dac;
    check("m_dac",    dac_o,    exp_dac);
    check("m_busy",   8'(busy_o),   8'(m_act));
    check("m_eoc",    8'(eoc_o),    8'(m_act && m_j == 40));
    check("m_dout",   dout_o,   m_dout);
    check("m_tx_stt", 8'(tx_stt_o), 8'(m_act && m_j == 41));
    check("m_tx_din", tx_din_o, m_txdin);
  end

  int eoc_cnt = 0;
  always @(negedge clk) if (eoc_o === 1'b1) eoc_cnt++;

  logic [7:0] seq_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

  task automatic start_pulse();
    @(posedge clk); #2 start_i = 1'b1;
    @(posedge clk); #2 start_i = 1'b0;
  endtask

  task automatic run(input logic [7:0] v, input logic [7:0] res, input bit chk_seq);
    vin = v;
    start_pulse();
    check("start_busy", 8'(busy_o), 8'h01);
    for (int b = 0; b < 8; b++) begin
      if (chk_seq) check("a5_trial", dac_o, seq_a5[b]);
      repeat (5) @(posedge clk);
      #2;
    end
    check("eoc_k40", 8'(eoc_o), 8'h01);
    check("dout_k40", dout_o, res);
    @(posedge clk); #2;
    check("eoc_k41", 8'(eoc_o), 8'h00);
`ifdef SAR_TX_EN
    check("tx_stt", 8'(tx_stt_o), 8'h01);
    check("tx_din", tx_din_o, res);
    repeat (19) @(posedge clk);
    #2 tx_eot_i = 1'b1;
    check("busy_wait_tx", 8'(busy_o), 8'h01);
    @(posedge clk); #2 tx_eot_i = 1'b0;
    check("busy_after_eot", 8'(busy_o), 8'h00);
`else
    check("busy_done", 8'(busy_o), 8'h00);
`endif
  endtask

  initial begin
    int e0;
    rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_dac", dac_o, 8'h00);
    check("rst_dout", dout_o, 8'h00);
    check("rst_busy", 8'(busy_o), 8'h00);
    check("rst_eoc", 8'(eoc_o), 8'h00);
    check("rst_tx_stt", 8'(tx_stt_o), 8'h00);
    rst_i = 1'b1;
    repeat (2) @(posedge clk);

    run(8'hA5, 8'hA5, 1'b1);
    run(8'h00, 8'h00, 1'b0);
    run(8'hFF, 8'hFF, 1'b0);

    // Second start 10 cycles in must be ignored; a stray tx_eot too.
    vin = 8'h5A;
    e0  = eoc_cnt;
    start_pulse();
    repeat (9) @(posedge clk);
    #2 start_i = 1'b1; tx_eot_i = 1'b1;
    @(posedge clk); #2 start_i = 1'b0; tx_eot_i = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    check("ign_eoc_count", 8'(eoc_cnt - e0), 8'h01);
    check("ign_dout", dout_o, 8'h5A);
`ifdef SAR_TX_EN
    tx_eot_i = 1'b1;
    @(posedge clk); #2 tx_eot_i = 1'b0;
`endif
    check("ign_busy", 8'(busy_o), 8'h00);

    // Reset in the middle of the third bit's settle window.
    vin = 8'h77;
    start_pulse();
    repeat (11) @(posedge clk);
    #3 rst_i = 1'b0;
    #1;
    check("arst_busy", 8'(busy_o), 8'h00);
    check("arst_dac", dac_o, 8'h00);
    check("arst_eoc", 8'(eoc_o), 8'h00);
    check("arst_dout", dout_o, 8'h00);
    e0 = eoc_cnt;
    repeat (3) @(posedge clk);
    #2 rst_i = 1'b1;
    repeat (50) @(posedge clk);
    #2;
    check("arst_no_eoc", 8'(eoc_cnt - e0), 8'h00);
    check("arst_idle", 8'(busy_o), 8'h00);

    run(8'h3C, 8'h3C, 1'b0);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sar_ctrl.md
# sar_ctrl

Successive-approximation ADC controller for the UART command path. It sits directly downstream of the command FSM's SAR-start strobe and directly upstream of the UART transmitter. On a start pulse it runs an N-bit binary search: it drives a DAC code, reads an external comparator through a synchronizer, and produces a conversion result. Optionally it hands the result byte to the transmitter and waits for end-of-transmission.

## Interface

Parameters:
- Nbits, 8, conversion resolution; legal range 2..8.
- SettleCycles, 4, cycles the DAC code is held before each comparator decision; legal minimum 2.

Ports:
- clk_i, in, 1, system clock; all state changes on its rising edge.
- rst_i, in, 1, reset; asynchronous, active-low.
- start_i, in, 1, conversion request; sampled only in IDLE.
- cmp_i, in, 1, external comparator; 1 means Vin >= Vdac; asynchronous to clk_i.
- dac_o, out, Nbits, current trial code driven to the DAC.
- dout_o, out, Nbits, last completed result; held until the next completion.
- busy_o, out, 1, high in every state except IDLE.
- eoc_o, out, 1, one-cycle end-of-conversion pulse.
- tx_stt_o, out, 1, one-cycle start strobe to the transmitter.
- tx_din_o, out, 8, byte for the transmitter; dout_o zero-extended on the left.
- tx_eot_i, in, 1, end-of-transmission pulse from the transmitter.

## Operation

- Reset values: all outputs 0. State is IDLE, the synchronizer flops are 0, and the bit index and settle counter are 0.
- cmp_i passes through a 2-flop synchronizer (cmp_s). Decisions use cmp_s only.
- States are IDLE, SETTLE, DECIDE, DONE, SEND and WAIT_TX.
- IDLE:
  - If start_i=1, go to SETTLE.
  - On entry to SETTLE, dac_o = only the MSB set, bit index = Nbits-1, settle counter = 0.
- SETTLE:
  - The counter increments each cycle.
  - After SettleCycles cycles in SETTLE, go to DECIDE.
- DECIDE (one cycle):
  - If cmp_s=0, clear dac_o[index]; if cmp_s=1, keep it.
  - If index>0: set dac_o[index-1], decrement index, clear the counter, go to SETTLE.
  - If index=0: load dout_o with the final code and go to DONE.
- DONE (one cycle):
  - eoc_o=1.
  - dac_o keeps the final code until the next start.
  - Next state is SEND if SAR_TX_EN is defined, otherwise IDLE.
- SEND (one cycle):
  - tx_stt_o=1.
  - tx_din_o is loaded with the result and held until the next SEND.
  - Go to WAIT_TX.
- WAIT_TX:
  - Stay until tx_eot_i=1, then go to IDLE.
  - There is no timeout.
- Boundary conditions:
  - start_i while busy_o=1 is ignored, not queued.
  - tx_eot_i is ignored outside WAIT_TX.
  - rst_i low at any point, mid-conversion or mid-transmit, returns everything to its reset values immediately. tx_stt_o falls asynchronously.
  - Result extremes: an all-zero result is reached by clearing every bit. An all-ones result keeps every bit.

## Timing

- start_i is sampled high at edge k.
- busy_o and the SETTLE entry values are visible after edge k.
- Each bit takes SettleCycles+1 cycles, so conversion is Nbits*(SettleCycles+1) cycles.
- eoc_o is high in the cycle after edge k+Nbits*(SettleCycles+1); with defaults, the cycle after edge k+40.
- dout_o is valid in the same cycle eoc_o is high.
- With SAR_TX_EN, tx_stt_o is high in the cycle immediately after eoc_o.
- busy_o falls on the edge after tx_eot_i is sampled high in WAIT_TX.
- Without SAR_TX_EN, busy_o falls on the edge ending DONE.
- The earliest accepted restart is the first IDLE cycle.
- SettleCycles>=2 guarantees cmp_s reflects the current dac_o at DECIDE when the comparator responds combinationally.

## Configuration

- SAR_TX_EN defined:
  - SEND and WAIT_TX are compiled in.
  - Every result is transmitted, and busy_o covers the transmission.
- SAR_TX_EN undefined:
  - SEND and WAIT_TX and the tx_din_o register are removed.
  - tx_stt_o and tx_din_o are tied to 0, and tx_eot_i is unused.
  - DONE returns straight to IDLE.

## Test plan

- Reset: hold rst_i low mid-run, then release -> all outputs 0, state IDLE, no eoc_o before the next start_i.
- Bench comparator cmp_i=(Vin>=dac_o), Vin=0xA5, start_i pulse at edge k -> dac_o trial sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5. Then eoc_o high in the cycle after edge k+40, dout_o=0xA5.
- Vin=0x00 -> dout_o=0x00. Vin=0xFF -> dout_o=0xFF. Both with the same latency.
- Second start_i pulse 10 cycles into a conversion -> ignored: a single eoc_o and an unchanged result.
- rst_i asserted in the middle of the third bit's SETTLE -> busy_o=0 and dac_o=0 immediately, no eoc_o. A fresh start then converts Vin=0x3C to 0x3C.
- SAR_TX_EN defined, Vin=0xA5 -> tx_stt_o pulse with tx_din_o=0xA5 the cycle after eoc_o. busy_o stays high until 1 edge after tx_eot_i, which the bench drives 20 cycles later.
